segment_writer: RTL and testbench

- DMA write engine directly downstream of the MMIO memory map.
- On `go`, writes a fixed number of cachelines to each of four segments in order (s0→s3), starting at the four segment base addresses.
- Counts write responses and reports the count on `cv_value`; asserts `done` once every issued write has been acknowledged.
- Output side connects to the DMA write channel, which applies backpressure via a full flag.

---
 rtl/segment_writer_if.sv | 34 +++
 rtl/segment_writer.sv | 147 ++++++++++++++
 tb/tb_segment_writer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_writer_if.sv
// DMA write-channel bundle between segment_writer (master) and the DMA write
// channel (slave).
//
// Handshake: dma_wr_en marks a valid request carrying dma_wr_addr/dma_wr_data
// for exactly one cycle. dma_wr_full acts as an inverted ready and is sampled
// by the master in the cycle it registers a request, so a request only appears
// on the cycle after a not-full sample. dma_wr_resp pulses once per
// acknowledged write.
interface segment_writer_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512
);
    logic                  dma_wr_full;
    logic                  dma_wr_en;
    logic [ADDR_WIDTH-1:0] dma_wr_addr;
    logic [DATA_WIDTH-1:0] dma_wr_data;
    logic                  dma_wr_resp;

    modport master (
        input  dma_wr_full,
        input  dma_wr_resp,
        output dma_wr_en,
        output dma_wr_addr,
        output dma_wr_data
    );

    modport slave (
        output dma_wr_full,
        output dma_wr_resp,
        input  dma_wr_en,
        input  dma_wr_addr,
        input  dma_wr_data
    );
endinterface

// File: rtl/segment_writer.sv
// segment_writer: on go, writes SEG_LINES cachelines to each of four segments
// (s0..s3) through the DMA write channel, counts write responses on cv_value
// and raises done once every issued write has been acknowledged.
//
// Optional feature macro: SEGMENT_WRITER_SKIP_NULL_EN
//   defined   -> segments whose latched base is 0 are skipped entirely.
//   undefined -> base 0 is an ordinary address; all four segments are written.
module segment_writer #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int SEG_LINES  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s0,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s1,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s2,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s3,
    input  logic                  go,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] cv_value,
    output logic [1:0]            dbg_state,
    segment_writer_if.master      dma
);

    localparam int LW = (SEG_LINES > 1) ? $clog2(SEG_LINES) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base [4];
    logic [3:0]            seg_mask;
    logic [1:0]            seg_idx;
    logic [LW-1:0]         line_idx;
    logic [ADDR_WIDTH-1:0] target;

    logic [3:0]            go_mask;
    logic [1:0]            go_first;
    logic                  go_any;
    logic [2:0]            go_pop;
    logic [1:0]            nxt_seg;
    logic                  nxt_any;
    logic [63:0]           issue_word;

    assign dbg_state = state;

    // Segment selection: which segments take part in a run, the first one,
    // how many there are, and the next active segment after the current one.
    always_comb begin
`ifdef SEGMENT_WRITER_SKIP_NULL_EN
        go_mask = {wr_addr_s3 != '0, wr_addr_s2 != '0,
                   wr_addr_s1 != '0, wr_addr_s0 != '0};
`else
        go_mask = 4'hf;
`endif
        go_any   = 1'b0;
        go_first = 2'd0;
        go_pop   = 3'd0;
        nxt_any  = 1'b0;
        nxt_seg  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (go_mask[i]) begin
                go_any   = 1'b1;
                go_first = 2'(i);
            end
            if (seg_mask[i] && (i > int'(seg_idx))) begin
                nxt_any = 1'b1;
                nxt_seg = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (go_mask[i]) begin
                go_pop = go_pop + 3'd1;
            end
        end
        issue_word = {32'(seg_idx), 32'(line_idx)};
    end

    // Control FSM with registered request outputs and response counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            for (int i = 0; i < 4; i++) begin
                base[i] <= '0;
            end
            seg_mask        <= '0;
            seg_idx         <= '0;
            line_idx        <= '0;
            target          <= '0;
            done            <= 1'b0;
            cv_value        <= '0;
            dma.dma_wr_en   <= 1'b0;
            dma.dma_wr_addr <= '0;
            dma.dma_wr_data <= '0;
        end else begin
            dma.dma_wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        base[0]  <= wr_addr_s0;
                        base[1]  <= wr_addr_s1;
                        base[2]  <= wr_addr_s2;
                        base[3]  <= wr_addr_s3;
                        seg_mask <= go_mask;
                        seg_idx  <= go_first;
                        line_idx <= '0;
                        target   <= ADDR_WIDTH'(SEG_LINES) * ADDR_WIDTH'(go_pop);
                        cv_value <= '0;
                        done     <= 1'b0;
                        state    <= go_any ? WRITE : DRAIN;
                    end
                end
                WRITE: begin
                    if (dma.dma_wr_resp) begin
                        cv_value <= cv_value + 1'b1;
                    end
                    if (!dma.dma_wr_full) begin
                        dma.dma_wr_en   <= 1'b1;
                        dma.dma_wr_addr <= base[seg_idx] + ADDR_WIDTH'(line_idx);
                        dma.dma_wr_data <= {(DATA_WIDTH/64){issue_word}};
                        if (line_idx == LW'(SEG_LINES - 1)) begin
                            line_idx <= '0;
                            if (nxt_any) begin
                                seg_idx <= nxt_seg;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            line_idx <= line_idx + LW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (dma.dma_wr_resp) begin
                        cv_value <= cv_value + 1'b1;
                    end
                    if (cv_value == target) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_writer.sv
// Testbench for segment_writer: table-driven runs, hand-written multi-cycle
// corner cases and randomized runs, all checked against a queue-based model
// of the expected request stream.
module tb_segment_writer;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int SL = 4;

`ifdef SEGMENT_WRITER_SKIP_NULL_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] wr_addr_s0, wr_addr_s1, wr_addr_s2, wr_addr_s3;
    logic          go;
    logic          done;
    logic [AW-1:0] cv_value;
    logic [1:0]    dbg_state;

    segment_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dma_if();

    segment_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_LINES(SL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_addr_s0 (wr_addr_s0),
        .wr_addr_s1 (wr_addr_s1),
        .wr_addr_s2 (wr_addr_s2),
        .wr_addr_s3 (wr_addr_s3),
        .go         (go),
        .done       (done),
        .cv_value   (cv_value),
        .dbg_state  (dbg_state),
        .dma        (dma_if.master)
    );

    // ---------------- scoreboard state ----------------
    logic [AW-1:0] exp_q[$];
    logic [63:0]   exp_w_q[$];
    int            checks = 0;
    int            errors = 0;
    int            n_issued = 0;
    int            n_resp = 0;
    int            pending = 0;
    int            resp_pct = 100;
    bit            hold = 1'b0;
    bit            flush = 1'b0;
    bit            inject = 1'b0;
    bit            prev_full = 1'b0;
    logic [DW-1:0] cap_data = '0;

    typedef struct {
        logic [AW-1:0] b0, b1, b2, b3;
        int            full_lo, full_hi;
        int            pct;
        int            exp_cnt;
        int            exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: observe/score at negedge, respond, then return #1 after posedge.
    task automatic cyc();
        logic [AW-1:0] a;
        logic [63:0]   w;
        logic [DW-1:0] d;
        @(negedge clk);
        if (flush) pending = 0;
        if (inject) pending++;
        if (dma_if.dma_wr_en === 1'b1) begin
            n_issued++;
            pending++;
            check64("en_after_full", 64'(prev_full), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req actual addr=%h required=no request", dma_if.dma_wr_addr);
            end else begin
                a = exp_q.pop_front();
                w = exp_w_q.pop_front();
                d = {8{w}};
                check64("req_addr", dma_if.dma_wr_addr, a);
                checks++;
                if (dma_if.dma_wr_data !== d) begin
                    errors++;
                    $display("FAIL req_data actual=%h required=%h", dma_if.dma_wr_data, d);
                end
            end
            if (dma_if.dma_wr_addr == 64'h301) cap_data = dma_if.dma_wr_data;
        end
        prev_full = dma_if.dma_wr_full;
        if (!hold && pending > 0 && $urandom_range(1, 100) <= resp_pct) begin
            dma_if.dma_wr_resp = 1'b1;
            pending--;
            n_resp++;
        end else begin
            dma_if.dma_wr_resp = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected request stream straight from the segment rules.
    task automatic build_exp(input logic [AW-1:0] b0, b1, b2, b3);
        logic [AW-1:0] b[4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        exp_q.delete();
        exp_w_q.delete();
        for (int s = 0; s < 4; s++) begin
            if (!(SKIP && b[s] == 0)) begin
                for (int l = 0; l < SL; l++) begin
                    exp_q.push_back(b[s] + AW'(l));
                    exp_w_q.push_back({32'(s), 32'(l)});
                end
            end
        end
    endtask

    task automatic start_run(input logic [AW-1:0] b0, b1, b2, b3, output int cnt, output int r0);
        wr_addr_s0 = b0; wr_addr_s1 = b1; wr_addr_s2 = b2; wr_addr_s3 = b3;
        build_exp(b0, b1, b2, b3);
        cnt = exp_q.size();
        r0 = n_resp;
        go = 1'b1;
        cyc();
        go = 1'b0;
        check64("done_drop", 64'(done), 64'd0);
    endtask

    task automatic wait_done(input int lo, input int hi, input bit rnd, input int budget, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < budget) begin
            dma_if.dma_wr_full = ((lat >= lo) && (lat <= hi)) || (rnd && $urandom_range(0, 3) == 0);
            cyc();
            lat++;
        end
        dma_if.dma_wr_full = 1'b0;
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual done=%b required done=1 within %0d cycles", done, budget);
        end
    endtask

    task automatic finish_run(input int exp_cnt, input int r0);
        int save;
        check64("done_level", 64'(done), 64'd1);
        check64("cv_at_done", cv_value, 64'(exp_cnt));
        check64("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check64("cv_vs_resp", cv_value, 64'(n_resp - r0));
        save = resp_pct;
        resp_pct = 100;
        inject = 1'b1;
        cyc();
        inject = 1'b0;
        cyc();
        cyc();
        check64("cv_resp_in_done", cv_value, 64'(exp_cnt));
        check64("done_held", 64'(done), 64'd1);
        check64("en_idle_done", 64'(dma_if.dma_wr_en), 64'd0);
        resp_pct = save;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, r0, lat, i0, early;
        logic [AW-1:0] rb[4];

        wr_addr_s0 = '0; wr_addr_s1 = '0; wr_addr_s2 = '0; wr_addr_s3 = '0;
        go = 1'b0;
        dma_if.dma_wr_full = 1'b0;
        dma_if.dma_wr_resp = 1'b0;

        vecs[0] = '{64'h100, 64'h200, 64'h300, 64'h400, -1, -1, 100, 16, 19};
        vecs[1] = '{64'h100, 64'h200, 64'h300, 64'h400, 3, 7, 100, 16, -1};
        vecs[2] = '{64'h1000, 64'h0, 64'h3000, 64'h4000, -1, -1, 100,
                    SKIP ? 12 : 16, SKIP ? 15 : 19};
        vecs[3] = '{64'h0, 64'h0, 64'h0, 64'h0, -1, -1, 100,
                    SKIP ? 0 : 16, SKIP ? 2 : 19};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h2, 64'h3, -1, -1, 50, 16, -1};
        vecs[5] = '{64'h100, 64'h200, 64'h300, 64'h400, -1, -1, 30, 16, -1};

        // Reset state
        cyc();
        cyc();
        check64("rst_done", 64'(done), 64'd0);
        check64("rst_cv", cv_value, 64'd0);
        check64("rst_en", 64'(dma_if.dma_wr_en), 64'd0);
        check64("rst_addr", dma_if.dma_wr_addr, 64'd0);
        check64("rst_data", 64'(|dma_if.dma_wr_data), 64'd0);
        check64("rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Table-driven runs
        for (int v = 0; v < 6; v++) begin
            resp_pct = vecs[v].pct;
            start_run(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, cnt, r0);
            wait_done(vecs[v].full_lo, vecs[v].full_hi, 1'b0, 400, lat);
            if (vecs[v].exp_lat >= 0) check64("done_latency", 64'(lat), 64'(vecs[v].exp_lat));
            finish_run(vecs[v].exp_cnt, r0);
            if (v == 0) check64("seg2_line1_data", cap_data[63:0], 64'h0000_0002_0000_0001);
            if (v == 0) check64("seg2_line1_data_hi", cap_data[DW-1:DW-64], 64'h0000_0002_0000_0001);
        end

        // Responses withheld until all requests are issued
        resp_pct = 100;
        hold = 1'b1;
        start_run(64'h100, 64'h200, 64'h300, 64'h400, cnt, r0);
        i0 = n_issued - 0;
        lat = 0;
        while (exp_q.size() != 0 && lat < 100) begin
            cyc();
            lat++;
        end
        cyc();
        cyc();
        cyc();
        check64("held_done", 64'(done), 64'd0);
        check64("held_cv", cv_value, 64'd0);
        hold = 1'b0;
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (done !== 1'b0) early++;
        end
        check64("held_no_early_done", 64'(early), 64'd0);
        check64("held_cv16", cv_value, 64'd16);
        cyc();
        check64("held_done_next", 64'(done), 64'd1);
        finish_run(16, r0);

        // go during WRITE is ignored
        start_run(64'h100, 64'h200, 64'h300, 64'h400, cnt, r0);
        cyc();
        cyc();
        wr_addr_s0 = 64'hF00; wr_addr_s1 = 64'hF10; wr_addr_s2 = 64'hF20; wr_addr_s3 = 64'hF30;
        go = 1'b1;
        cyc();
        go = 1'b0;
        wait_done(-1, -1, 1'b0, 400, lat);
        finish_run(16, r0);

        // Reset mid-run, then a fresh run
        start_run(64'h100, 64'h200, 64'h300, 64'h400, cnt, r0);
        i0 = n_issued;
        lat = 0;
        while (n_issued - i0 < 5 && lat < 100) begin
            cyc();
            lat++;
        end
        rst_n = 1'b0;
        hold = 1'b1;
        cyc();
        check64("mid_rst_done", 64'(done), 64'd0);
        check64("mid_rst_cv", cv_value, 64'd0);
        check64("mid_rst_en", 64'(dma_if.dma_wr_en), 64'd0);
        check64("mid_rst_addr", dma_if.dma_wr_addr, 64'd0);
        check64("mid_rst_data", 64'(|dma_if.dma_wr_data), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        exp_w_q.delete();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        hold = 1'b0;
        cyc();
        cyc();
        start_run(64'h500, 64'h600, 64'h700, 64'h800, cnt, r0);
        i0 = n_issued;
        wait_done(-1, -1, 1'b0, 400, lat);
        check64("post_rst_issued", 64'(n_issued - i0), 64'd16);
        finish_run(16, r0);

        // Randomized runs with random backpressure and response timing
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < 4; s++) begin
                rb[s] = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
            end
            resp_pct = $urandom_range(20, 100);
            start_run(rb[0], rb[1], rb[2], rb[3], cnt, r0);
            wait_done(-1, -1, 1'b1, 2000, lat);
            finish_run(cnt, r0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
